main_onewire: RTL and testbench

MAIN_ONEWIRE -- requirements
Module: main_onewire

---
 rtl/main_onewire.sv | 243 ++++++++++++++++++++++++
 tb/tb_main_onewire.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/main_onewire.sv
// DS18B20-style 1-Wire thermometer master: convert, read scratchpad, show whole degrees on three 7-segment digits.
// Optional PRESENCE_CHECK_EN: skip the transaction and retry after 1000 us when no presence pulse answers a bus reset.
module main_onewire #(
   parameter int unsigned CLKS_PER_US = 1,
   parameter int unsigned CONV_US     = 750000
) (
   input  logic       CLOCK_27,
   inout  wire        GPIO,
   input  logic [0:0] SW,
   output logic [1:0] LEDR,
   output logic [6:0] HEX1,
   output logic [6:0] HEX2,
   output logic [6:0] HEX3,
   input  logic       KEY,
   input  logic       in,
   output logic       out
);

   // Terminal counts: the timer restarts at 0 on every state or slot entry.
   localparam logic [31:0] C_6    = 32'(6 * CLKS_PER_US - 1);
   localparam logic [31:0] C_15   = 32'(15 * CLKS_PER_US - 1);
   localparam logic [31:0] C_60   = 32'(60 * CLKS_PER_US - 1);
   localparam logic [31:0] C_70   = 32'(70 * CLKS_PER_US - 1);
   localparam logic [31:0] C_480  = 32'(480 * CLKS_PER_US - 1);
   localparam logic [31:0] C_CONV = 32'(CONV_US * CLKS_PER_US - 1);
`ifdef PRESENCE_CHECK_EN
   localparam logic [31:0] C_1000 = 32'(1000 * CLKS_PER_US - 1);
`endif

   localparam logic [7:0] CMD_SKIP_ROM = 8'hCC;
   localparam logic [7:0] CMD_CONVERT  = 8'h44;
   localparam logic [7:0] CMD_READ     = 8'hBE;
   localparam logic [6:0] SEG_BLANK    = 7'h7F;
   localparam logic [6:0] SEG_MINUS    = 7'h3F;
   localparam logic [6:0] SEG_ONE      = 7'h79;

   typedef enum logic [2:0] {
      IDLE, RST_LOW, RST_WAIT, TX_BYTE, CONV_WAIT, RX_BYTES, UPDATE, RETRY
   } state_t;

   state_t      state;
   logic [31:0] timer;
   logic [3:0]  bit_cnt;
   logic        tx_idx;      // 0: skip-ROM byte, 1: function command byte
   logic        read_phase;  // 0: convert transaction, 1: read transaction
   logic [15:0] raw;

   // Open-drain pad: only ever pull low, never drive high.
   assign GPIO = out ? 1'bz : 1'b0;

   function automatic logic [6:0] seg7(input logic [7:0] d);
      case (d)
         8'd0:    seg7 = 7'h40;
         8'd1:    seg7 = 7'h79;
         8'd2:    seg7 = 7'h24;
         8'd3:    seg7 = 7'h30;
         8'd4:    seg7 = 7'h19;
         8'd5:    seg7 = 7'h12;
         8'd6:    seg7 = 7'h02;
         8'd7:    seg7 = 7'h78;
         8'd8:    seg7 = 7'h00;
         8'd9:    seg7 = 7'h10;
         default: seg7 = SEG_BLANK;
      endcase
   endfunction

   logic [7:0]  tx_byte;
   logic        tx_bit;
   logic [31:0] tx_low_end;
   logic [15:0] abs_raw;
   logic [7:0]  mag;
   logic [7:0]  tens;
   logic [7:0]  units;
   logic [6:0]  seg_sign;
   logic [6:0]  seg_tens;
   logic [6:0]  seg_units;

   always_comb begin
      tx_byte    = (tx_idx == 1'b0) ? CMD_SKIP_ROM : (read_phase ? CMD_READ : CMD_CONVERT);
      tx_bit     = tx_byte[bit_cnt[2:0]];
      tx_low_end = tx_bit ? C_6 : C_60;

      // Negating before the shift truncates negative readings toward zero.
      abs_raw = raw[15] ? (~raw + 16'd1) : raw;
      mag     = 8'(abs_raw >> 4);
      tens    = (mag / 8'd10) % 8'd10;
      units   = mag % 8'd10;

      if (raw[15])
         seg_sign = SEG_MINUS;
      else if (mag >= 8'd100)
         seg_sign = SEG_ONE;
      else
         seg_sign = SEG_BLANK;
      seg_tens  = (mag < 8'd10) ? SEG_BLANK : seg7(tens);
      seg_units = seg7(units);
   end

   always_ff @(posedge CLOCK_27 or posedge KEY) begin
      if (KEY) begin
         state      <= IDLE;
         out        <= 1'b1;
         LEDR       <= 2'b00;
         HEX1       <= SEG_BLANK;
         HEX2       <= SEG_BLANK;
         HEX3       <= SEG_BLANK;
         raw        <= '0;
         timer      <= '0;
         bit_cnt    <= '0;
         tx_idx     <= 1'b0;
         read_phase <= 1'b0;
      end else begin
         // NOTE: the free-running increment is a default; a later non-blocking
         // assignment to timer in the same branch wins and restarts it.
         timer <= timer + 32'd1;
         case (state)
            IDLE: begin
               out   <= 1'b1;
               timer <= '0;
               if (SW[0]) begin
                  state      <= RST_LOW;
                  out        <= 1'b0;
                  read_phase <= 1'b0;
               end
            end

            RST_LOW: begin
               if (timer == C_480) begin
                  state <= RST_WAIT;
                  out   <= 1'b1;
                  timer <= '0;
               end
            end

            RST_WAIT: begin
               if (timer == C_70)
                  LEDR[0] <= ~in;
               if (timer == C_480) begin
                  timer   <= '0;
                  bit_cnt <= '0;
                  tx_idx  <= 1'b0;
`ifdef PRESENCE_CHECK_EN
                  if (!LEDR[0]) begin
                     state <= RETRY;
                  end else begin
                     state <= TX_BYTE;
                     out   <= 1'b0;
                  end
`else
                  state <= TX_BYTE;
                  out   <= 1'b0;
`endif
               end
            end

            TX_BYTE: begin
               if (timer == tx_low_end)
                  out <= 1'b1;
               if (timer == C_70) begin
                  timer <= '0;
                  if (bit_cnt == 4'd7) begin
                     bit_cnt <= '0;
                     if (tx_idx == 1'b0) begin
                        tx_idx <= 1'b1;
                        out    <= 1'b0;
                     end else if (read_phase) begin
                        state <= RX_BYTES;
                        out   <= 1'b0;
                     end else begin
                        state <= CONV_WAIT;
                        out   <= 1'b1;
                     end
                  end else begin
                     bit_cnt <= bit_cnt + 4'd1;
                     out     <= 1'b0;
                  end
               end
            end

            CONV_WAIT: begin
               if (timer == C_CONV) begin
                  timer <= '0;
                  if (SW[0]) begin
                     state      <= RST_LOW;
                     out        <= 1'b0;
                     read_phase <= 1'b1;
                  end else begin
                     state <= IDLE;
                  end
               end
            end

            RX_BYTES: begin
               if (timer == C_6)
                  out <= 1'b1;
               if (timer == C_15)
                  raw <= {in, raw[15:1]};
               if (timer == C_70) begin
                  timer <= '0;
                  if (bit_cnt == 4'd15) begin
                     bit_cnt <= '0;
                     state   <= UPDATE;
                     out     <= 1'b1;
                  end else begin
                     bit_cnt <= bit_cnt + 4'd1;
                     out     <= 1'b0;
                  end
               end
            end

            UPDATE: begin
               HEX3    <= seg_sign;
               HEX2    <= seg_tens;
               HEX1    <= seg_units;
               LEDR[1] <= 1'b1;
               timer   <= '0;
               state   <= IDLE;
            end

`ifdef PRESENCE_CHECK_EN
            RETRY: begin
               if (timer == C_1000) begin
                  timer <= '0;
                  if (SW[0]) begin
                     state <= RST_LOW;
                     out   <= 1'b0;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
`endif

            default: begin
               state <= IDLE;
               out   <= 1'b1;
               timer <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_main_onewire.sv
// Directed bench for main_onewire with a behavioural DS18B20-like slave on the bus.
module tb_main_onewire;

   logic       clk = 1'b0;
   logic       key;
   logic [0:0] sw;
   logic       dut_in;
   logic       dut_out;
   logic [1:0] ledr;
   logic [6:0] hex1;
   logic [6:0] hex2;
   logic [6:0] hex3;
   wire        gpio;

   pullup (gpio);

   int checks = 0;
   int errors = 0;

   // Slave model state
   logic        slave_pull = 1'b0;
   logic        present    = 1'b1;
   logic [15:0] raw_val    = 16'h0000;
   logic        prev_out   = 1'b1;
   logic        rd_mode    = 1'b0;
   logic [7:0]  wr_byte    = 8'h00;
   int          low_cnt    = 0;
   int          pull_wait  = 0;
   int          pull_len   = 0;
   int          wr_bits    = 0;
   int          rd_bit     = 0;
   int          cyc        = 0;
   int          fall_t[$];
   int          pulse_w[$];
   logic [7:0]  cmd_log[$];

   int          exp_w[8] = '{60, 60, 6, 6, 60, 60, 6, 6};
   logic [7:0]  exp_cmd[4] = '{8'hCC, 8'h44, 8'hCC, 8'hBE};

   always #5 clk = ~clk;

   assign dut_in = dut_out & ~slave_pull;

   main_onewire #(.CLKS_PER_US(1), .CONV_US(100)) dut (
      .CLOCK_27 (clk),
      .GPIO     (gpio),
      .SW       (sw),
      .LEDR     (ledr),
      .HEX1     (hex1),
      .HEX2     (hex2),
      .HEX3     (hex3),
      .KEY      (key),
      .in       (dut_in),
      .out      (dut_out)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Slave: answers bus resets with presence, decodes written bytes, serves raw_val after 0xBE.
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (pull_wait != 0)
            pull_wait--;
         else if (pull_len != 0) begin
            slave_pull = 1'b1;
            pull_len--;
         end else
            slave_pull = 1'b0;

         if (prev_out && !dut_out) begin
            fall_t.push_back(cyc);
            low_cnt = 0;
            if (rd_mode) begin
               if (!raw_val[rd_bit]) begin
                  pull_len   = 30;
                  slave_pull = 1'b1;
               end
               rd_bit++;
               if (rd_bit == 16)
                  rd_mode = 1'b0;
            end
         end
         if (!dut_out)
            low_cnt++;
         if (!prev_out && dut_out) begin
            pulse_w.push_back(low_cnt);
            if (low_cnt >= 400) begin
               if (present) begin
                  pull_wait = 20;
                  pull_len  = 100;
               end
               wr_bits = 0;
               rd_mode = 1'b0;
            end else if (!rd_mode) begin
               wr_byte = {low_cnt < 15, wr_byte[7:1]};
               wr_bits++;
               if (wr_bits == 8) begin
                  cmd_log.push_back(wr_byte);
                  wr_bits = 0;
                  if (wr_byte == 8'hBE) begin
                     rd_mode = 1'b1;
                     rd_bit  = 0;
                  end
               end
            end
         end
         prev_out = dut_out;
      end
   end

   initial begin
      int n;
      int lows;
      key = 1'b1;
      sw  = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_out", 32'(dut_out), 1);
      check("rst_gpio_released", 32'(gpio), 1);
      check("rst_ledr", 32'(ledr), 0);
      check("rst_hex1", 32'(hex1), 32'h7F);
      check("rst_hex2", 32'(hex2), 32'h7F);
      check("rst_hex3", 32'(hex3), 32'h7F);

      // Disabled: bus stays released for 10 ms
      key  = 1'b0;
      lows = 0;
      repeat (10000) begin
         @(negedge clk);
         if (!dut_out) lows++;
      end
      check("idle_low_cycles", 32'(lows), 0);

      // Run 1: +25 C (raw 0x0191)
      present = 1'b1;
      raw_val = 16'h0191;
      fall_t.delete();
      pulse_w.delete();
      cmd_log.delete();
      sw = 1'b1;
      n  = 0;
      while (fall_t.size() == 0 && n < 100) begin @(negedge clk); n++; end
      check("run1_start_timeout", 32'(n < 100), 1);
      check("gpio_pulled_low", 32'(gpio), 0);
      n = 0;
      while (ledr[1] == 1'b0 && n < 10000) begin @(negedge clk); n++; end
      check("run1_done_timeout", 32'(n < 10000), 1);
      sw = 1'b0;
      check("reset_pulse_width", 32'(pulse_w[0]), 480);
      check("reset_to_first_slot", 32'(fall_t[1] - fall_t[0]), 960);
      for (int i = 0; i < 8; i++)
         check($sformatf("tx_cc_low%0d", i), 32'(pulse_w[i+1]), 32'(exp_w[i]));
      for (int i = 1; i < 8; i++)
         check($sformatf("tx_cc_spacing%0d", i), 32'(fall_t[i+1] - fall_t[i]), 70);
      check("cmd_count", 32'(cmd_log.size()), 4);
      for (int i = 0; i < 4; i++)
         check($sformatf("cmd%0d", i), 32'(cmd_log[i]), 32'(exp_cmd[i]));
      check("run1_ledr", 32'(ledr), 3);
      check("run1_hex3", 32'(hex3), 32'h7F);
      check("run1_hex2", 32'(hex2), 32'h24);
      check("run1_hex1", 32'(hex1), 32'h12);

      // Run 2: SW drops during convert; only the convert transaction completes
      repeat (5) @(negedge clk);
      fall_t.delete();
      raw_val = 16'hFF5E;
      sw = 1'b1;
      n  = 0;
      while (fall_t.size() == 0 && n < 100) begin @(negedge clk); n++; end
      check("run2_start_timeout", 32'(n < 100), 1);
      sw = 1'b0;
      repeat (3000) @(negedge clk);
      check("run2_fall_count", 32'(fall_t.size()), 17);
      check("run2_hex1_held", 32'(hex1), 32'h12);
      check("run2_out_idle", 32'(dut_out), 1);

      // Run 3: -10 C (raw 0xFF5E)
      sw = 1'b1;
      n  = 0;
      while (hex3 == 7'h7F && n < 10000) begin @(negedge clk); n++; end
      check("run3_done_timeout", 32'(n < 10000), 1);
      sw = 1'b0;
      check("run3_hex3", 32'(hex3), 32'h3F);
      check("run3_hex2", 32'(hex2), 32'h79);
      check("run3_hex1", 32'(hex1), 32'h40);
      check("run3_ledr", 32'(ledr), 3);

      // Run 4: no presence pulse
      repeat (5) @(negedge clk);
      present = 1'b0;
      raw_val = 16'h0640;
      fall_t.delete();
      sw = 1'b1;
`ifdef PRESENCE_CHECK_EN
      repeat (2500) @(negedge clk);
      sw = 1'b0;
      check("retry_gap", 32'(fall_t[1] - fall_t[0]), 1960);
      check("retry_hex3_held", 32'(hex3), 32'h3F);
      check("retry_ledr", 32'(ledr), 2);
      repeat (2000) @(negedge clk);
`else
      n = 0;
      while (hex3 == 7'h3F && n < 10000) begin @(negedge clk); n++; end
      check("run4_done_timeout", 32'(n < 10000), 1);
      sw = 1'b0;
      check("run4_first_slot", 32'(fall_t[1] - fall_t[0]), 960);
      check("run4_hex3", 32'(hex3), 32'h79);
      check("run4_hex2", 32'(hex2), 32'h40);
      check("run4_hex1", 32'(hex1), 32'h40);
      check("run4_ledr", 32'(ledr), 2);
`endif
      present = 1'b1;

      // Run 5: KEY while the bus is held low releases it at once
      repeat (5) @(negedge clk);
      sw = 1'b1;
      n  = 0;
      while (dut_out == 1'b1 && n < 100) begin @(negedge clk); n++; end
      check("run5_start_timeout", 32'(n < 100), 1);
      repeat (100) @(negedge clk);
      sw  = 1'b0;
      key = 1'b1;
      #1;
      check("key_releases_out", 32'(dut_out), 1);
      check("key_releases_gpio", 32'(gpio), 1);
      @(negedge clk);
      check("key_clears_ledr", 32'(ledr), 0);
      check("key_blanks_hex1", 32'(hex1), 32'h7F);
      check("key_blanks_hex3", 32'(hex3), 32'h7F);
      key = 1'b0;
      repeat (20) @(negedge clk);
      check("after_key_idle", 32'(dut_out), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
